// File: rtl/fetch_decode_latch_pkg.sv
// Shared constants for the fetch-to-decode boundary stage.
package fetch_decode_latch_pkg;

  localparam int unsigned FDL_DW = 32;

  // Instruction word used for bubbles in decode.
  localparam logic [FDL_DW-1:0] FDL_NOP = 32'h0000_0000;

  // PC reset vector.
  localparam logic [FDL_DW-1:0] FDL_PC_RESET = 32'h0000_0000;

endpackage

// File: rtl/fetch_decode_latch_fd_reg.sv
// Generic pipeline register: per-bit flip-flops with load enable and a
// synchronous clear that returns every bit to RST_VAL.
module fd_reg #(
  parameter int unsigned  W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  for (genvar i = 0; i < int'(W); i++) begin : g_bit
    logic q_bit;

    // Single bit: reset/clear dominate, otherwise load when enabled.
    always_ff @(posedge clock) begin
      if (reset || clr) begin
        q_bit <= RST_VAL[i];
      end else if (en) begin
        q_bit <= d[i];
      end
    end

    assign q[i] = q_bit;
  end

endmodule

// File: rtl/fetch_decode_latch.sv
// Fetch-to-decode boundary: aligns each fetch PC with the 1-cycle-late imem
// data, holds it across decode stalls with a 1-entry skid, and drops in-flight
// fetches on a flush.
module fetch_decode_latch
  import fetch_decode_latch_pkg::*;
#(
  parameter int unsigned   DW  = FDL_DW,
  parameter logic [DW-1:0] NOP = DW'(FDL_NOP)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [DW-1:0] pc_in,
  input  logic [DW-1:0] pc_seq,
  input  logic [DW-1:0] imem_q,
  input  logic          stall,
  input  logic          flush,
  output logic          pc_ena,
  output logic [DW-1:0] fd_pc,
  output logic [DW-1:0] fd_pc_seq,
  output logic [DW-1:0] fd_instr,
  output logic          fd_valid
);

  localparam logic [2*DW-1:0] PC_PAIR_RST = {DW'(FDL_PC_RESET), DW'(FDL_PC_RESET)};

  logic [2*DW-1:0] a_pair;
  logic [2*DW-1:0] fd_pair;
  logic [DW-1:0]   a_pc;
  logic [DW-1:0]   a_pc_seq;
  logic            a_valid;
  logic [DW-1:0]   s_instr;
  logic            s_full;
  logic [DW-1:0]   a_instr;
  logic [DW-1:0]   fd_instr_d;

  logic advance_en;
  logic kill_clr;
  logic skid_load;
  logic skid_full_clr;
  logic skid_full_en;

  // Stage control: flush beats stall, stall beats advance.
  always_comb begin
    advance_en    = 1'b0;
    kill_clr      = 1'b0;
    skid_load     = 1'b0;
    skid_full_clr = 1'b0;
    skid_full_en  = 1'b0;

    kill_clr      = flush;
    advance_en    = ~stall & ~flush;
    // Capture imem data for a_pc on the first stalled edge only; later
    // stalled edges would see data for the held (next) PC instead.
    skid_load     = stall & ~flush & ~s_full;
    skid_full_en  = stall & ~flush;
    skid_full_clr = flush | ~stall;
  end

  // PC register may load whenever decode accepts, and always on a redirect.
  assign pc_ena = ~stall | flush;

  // Instruction matching a_pc: skid once captured, else live imem data.
  assign a_instr    = s_full ? s_instr : imem_q;
  assign fd_instr_d = a_valid ? a_instr : NOP;

  fd_reg #(.W(2*DW), .RST_VAL(PC_PAIR_RST)) u_align_pc (
    .clock (clock), .reset (reset), .clr (1'b0), .en (advance_en),
    .d     ({pc_in, pc_seq}), .q (a_pair)
  );

  fd_reg #(.W(1), .RST_VAL(1'b0)) u_align_valid (
    .clock (clock), .reset (reset), .clr (kill_clr), .en (advance_en),
    .d     (1'b1), .q (a_valid)
  );

  fd_reg #(.W(DW), .RST_VAL(NOP)) u_skid_instr (
    .clock (clock), .reset (reset), .clr (1'b0), .en (skid_load),
    .d     (imem_q), .q (s_instr)
  );

  fd_reg #(.W(1), .RST_VAL(1'b0)) u_skid_full (
    .clock (clock), .reset (reset), .clr (skid_full_clr), .en (skid_full_en),
    .d     (1'b1), .q (s_full)
  );

  fd_reg #(.W(2*DW), .RST_VAL(PC_PAIR_RST)) u_fd_pc (
    .clock (clock), .reset (reset), .clr (1'b0), .en (advance_en),
    .d     (a_pair), .q (fd_pair)
  );

  fd_reg #(.W(DW), .RST_VAL(NOP)) u_fd_instr (
    .clock (clock), .reset (reset), .clr (kill_clr), .en (advance_en),
    .d     (fd_instr_d), .q (fd_instr)
  );

  fd_reg #(.W(1), .RST_VAL(1'b0)) u_fd_valid (
    .clock (clock), .reset (reset), .clr (kill_clr), .en (advance_en),
    .d     (a_valid), .q (fd_valid)
  );

  assign a_pc      = a_pair[2*DW-1:DW];
  assign a_pc_seq  = a_pair[DW-1:0];
  assign fd_pc     = fd_pair[2*DW-1:DW];
  assign fd_pc_seq = fd_pair[DW-1:0];

  // a_pc_seq only rides along to decode; a_pc is kept for readability in waves.
  logic unused_align;
  assign unused_align = ^{a_pc, a_pc_seq};

endmodule
